// File: rtl/controller_mc.sv
// rtl/controller_mc.sv - multicycle LEGv8 controller with memory watchdog, sticky fault and retire counter
//
// Purpose: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB,
// handshaking with instruction and data memory, and drives the datapath
// control set as Moore outputs of the state and the latched opcode.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   instr[10:0]            opcode field of the fetched word, valid with imem_ack
//   imem_ack, dmem_ack     memory acknowledges
//   imem_req, dmem_req     memory requests
//   ir_write, pc_write     IR / PC write enables
//   reg2loc .. branchTipe  datapath controls (single-cycle controller meanings)
//   AluControl[3:0]        ALU operation
//   fault                  sticky fault flag (illegal opcode or memory timeout)
//   retired[RET_W-1:0]     completed-instruction count, wraps

module controller_mc #(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg2loc,
    output logic             regWrite,
    output logic             AluSrc,
    output logic             Branch,
    output logic             memtoReg,
    output logic             memRead,
    output logic             memWrite,
    output logic             branchTipe,
    output logic [3:0]       AluControl,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    // The watchdog only ever needs to reach TIMEOUT-1.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    logic [2:0]       state_q, state_d;
    logic [10:0]      op_q;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [RET_W-1:0] ret_q;

    logic is_ldur, is_stur, is_cb, is_rtype, is_legal, expire;
    logic [3:0] alu_op;

    assign is_ldur  = (op_q == 11'b11111000010);
    assign is_stur  = (op_q == 11'b11111000000);
    // CBZ and CBNZ differ only in op[3]; op[2:0] are don't-care.
    assign is_cb    = (op_q[10:4] == 7'b1011010);
    assign is_rtype = (op_q == 11'b10001011000) || (op_q == 11'b11001011000) ||
                      (op_q == 11'b10001010000) || (op_q == 11'b10101010000);
    assign is_legal = is_ldur || is_stur || is_cb || is_rtype;

    always_comb begin
        alu_op = 4'b0010;
        if (op_q == 11'b10001010000)      alu_op = 4'b0000;
        else if (op_q == 11'b10101010000) alu_op = 4'b0001;
        else if (op_q == 11'b11001011000) alu_op = 4'b0110;
        else if (is_cb)                   alu_op = 4'b0111;
    end

    // Only meaningful in a wait cycle (FETCH or MEM without ack).
    assign expire = (TIMEOUT > 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        wd_d       = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg2loc    = 1'b0;
        regWrite   = 1'b0;
        AluSrc     = 1'b0;
        Branch     = 1'b0;
        memtoReg   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        branchTipe = 1'b0;
        AluControl = 4'b0000;
        fault      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Reset parks the machine in FETCH; the request stays masked until release.
                imem_req = !reset;
                ir_write = !reset && imem_ack;
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (expire) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                reg2loc = is_stur || is_cb;
                state_d = is_legal ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                AluControl = alu_op;
                reg2loc    = is_stur || is_cb;
                AluSrc     = is_ldur || is_stur;
                if (is_cb) begin
                    Branch     = 1'b1;
                    branchTipe = op_q[3];
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_ldur || is_stur) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                AluSrc     = 1'b1;
                AluControl = alu_op;
                memRead    = is_ldur;
                memWrite   = is_stur;
                if (dmem_ack) begin
                    if (is_ldur) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (expire) state_d = S_FAULT;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                memtoReg = is_ldur;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wd_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (ir_write) op_q  <= instr;
            if (pc_write) ret_q <= ret_q + RET_W'(1);
        end
    end

    assign retired = ret_q;

endmodule

// File: tb/tb_controller_mc.sv
// tb/tb_controller_mc.sv - self-checking bench for controller_mc

module tb_controller_mc;

    localparam int TO = 4;
    localparam int RW = 3;

    localparam logic [16:0] IREQ = 17'h10000;
    localparam logic [16:0] DREQ = 17'h08000;
    localparam logic [16:0] IRW  = 17'h04000;
    localparam logic [16:0] PCW  = 17'h02000;
    localparam logic [16:0] R2L  = 17'h01000;
    localparam logic [16:0] RGW  = 17'h00800;
    localparam logic [16:0] ASRC = 17'h00400;
    localparam logic [16:0] BR   = 17'h00200;
    localparam logic [16:0] M2R  = 17'h00100;
    localparam logic [16:0] MRD  = 17'h00080;
    localparam logic [16:0] MWR  = 17'h00040;
    localparam logic [16:0] BT   = 17'h00020;
    localparam logic [16:0] FLT  = 17'h00001;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100110;
    localparam logic [10:0] OP_CBNZ = 11'b10110101011;

    logic clk = 1'b0;
    logic reset;
    logic [10:0] instr;
    logic imem_ack, dmem_ack;
    logic imem_req, dmem_req, ir_write, pc_write, reg2loc, regWrite, AluSrc;
    logic Branch, memtoReg, memRead, memWrite, branchTipe, fault;
    logic [3:0] AluControl;
    logic [RW-1:0] retired;

    controller_mc #(.TIMEOUT(TO), .RET_W(RW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
        .reg2loc(reg2loc), .regWrite(regWrite), .AluSrc(AluSrc), .Branch(Branch),
        .memtoReg(memtoReg), .memRead(memRead), .memWrite(memWrite), .branchTipe(branchTipe),
        .AluControl(AluControl), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ret_m  = 0;
    int cyc_n  = 0;
    bit chk_en = 0;
    logic [16:0] exp_vec;
    logic [RW-1:0] exp_ret;
    string tag = "";

    wire [16:0] act_vec = {imem_req, dmem_req, ir_write, pc_write, reg2loc, regWrite, AluSrc,
                           Branch, memtoReg, memRead, memWrite, branchTipe, AluControl, fault};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act_vec !== exp_vec || retired !== exp_ret) begin
                errors++;
                $display("FAIL %s: outputs %h retired %0d, expected %h retired %0d",
                         tag, act_vec, retired, exp_vec, exp_ret);
            end
        end
    end

    task automatic check(input string t, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", t, act, expv);
        end
    endtask

    task automatic step(input logic [16:0] v, input logic ia, input logic da,
                        input logic [10:0] ins, input string t);
        imem_ack = ia;
        dmem_ack = da;
        instr    = ins;
        exp_vec  = v;
        exp_ret  = RW'(ret_m);
        tag      = t;
        chk_en   = 1;
        @(posedge clk);
        #1;
        if (v[13]) ret_m = (ret_m + 1) % (1 << RW);
        cyc_n++;
    endtask

    function automatic logic [3:0] alu_of(input logic [10:0] op);
        if (op == OP_AND) return 4'b0000;
        if (op == OP_ORR) return 4'b0001;
        if (op == OP_SUB) return 4'b0110;
        if (op[10:4] == 7'b1011010) return 4'b0111;
        return 4'b0010;
    endfunction

    task automatic fault_cycles(input int n, input logic noise);
        for (int i = 0; i < n; i++) step(FLT, noise, noise, 11'($urandom), "fault_hold");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ret_m = 0;
        for (int i = 0; i < 2; i++) step('0, 1'b1, 1'b1, 11'($urandom), "in_reset");
        reset = 1'b0;
    endtask

    // Expected per-cycle trace of one instruction, from its class and the
    // number of wait cycles imposed on each memory.
    task automatic run(input logic [10:0] op, input int iw, input int dw, input logic noise,
                       input string nm);
        logic ld, st, cb, rt;
        logic [16:0] a, r2, v;
        ld = (op == OP_LDUR);
        st = (op == OP_STUR);
        cb = (op[10:4] == 7'b1011010);
        rt = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
        a  = {12'b0, alu_of(op), 1'b0};
        r2 = (st || cb) ? R2L : '0;
        cyc_n = 0;
        for (int i = 0; i < iw && i < TO; i++) step(IREQ, 1'b0, noise, 11'($urandom), {nm, "_fetch_wait"});
        if (iw >= TO) begin fault_cycles(5, noise); return; end
        step(IREQ | IRW, 1'b1, noise, op, {nm, "_fetch"});
        step(r2, noise, noise, 11'($urandom), {nm, "_decode"});
        if (!(ld || st || cb || rt)) begin fault_cycles(20, noise); return; end
        v = a | r2 | ((ld || st) ? ASRC : '0) | (cb ? (BR | PCW | (op[3] ? BT : '0)) : '0);
        step(v, noise, noise, 11'($urandom), {nm, "_exec"});
        if (cb) return;
        if (ld || st) begin
            v = DREQ | ASRC | a | (ld ? MRD : MWR);
            for (int i = 0; i < dw && i < TO; i++) step(v, noise, 1'b0, 11'($urandom), {nm, "_mem_wait"});
            if (dw >= TO) begin fault_cycles(5, noise); return; end
            step(v | (st ? PCW : '0), noise, 1'b1, 11'($urandom), {nm, "_mem_ack"});
            if (st) return;
        end
        step(RGW | PCW | (ld ? M2R : '0), noise, noise, 11'($urandom), {nm, "_wb"});
    endtask

    initial begin
        reset = 1'b1; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
        do_reset();

        run(OP_ADD, 0, 0, 1'b1, "add");
        check("add_cycles", cyc_n, 4);
        check("add_retired", int'(retired), 1);

        run(OP_LDUR, 0, 3, 1'b0, "ldur");
        check("ldur_cycles", cyc_n, 8);

        run(OP_CBNZ, 0, 0, 1'b0, "cbnz");
        check("cbnz_cycles", cyc_n, 3);
        run(OP_CBZ, 1, 0, 1'b1, "cbz");
        run(OP_SUB, 2, 0, 1'b0, "sub");
        run(OP_AND, 0, 0, 1'b1, "and");
        run(OP_ORR, 0, 0, 1'b0, "orr");
        run(OP_STUR, 0, 2, 1'b1, "stur");
        check("mix_retired", int'(retired), 8 % 8);

        run(11'b00000000000, 0, 0, 1'b1, "illegal");
        check("illegal_fault", int'(fault), 1);
        do_reset();
        check("fault_cleared", int'(fault), 0);
        run(OP_ADD, 0, 0, 1'b0, "post_fault_add");

        // Fetch watchdog: four unanswered wait cycles end in FAULT.
        do_reset();
        for (int i = 0; i < 4; i++) step(IREQ, 1'b0, 1'b0, 11'd0, "to_wait");
        check("timeout_fault", int'(fault), 1);
        check("timeout_no_req", int'(imem_req), 0);
        fault_cycles(3, 1'b1);

        // Ack in the last permitted wait cycle wins.
        do_reset();
        run(OP_ADD, 3, 0, 1'b0, "late_ack");
        check("late_ack_cycles", cyc_n, 7);
        run(OP_LDUR, 0, 3, 1'b1, "late_dack");
        run(OP_STUR, 0, 4, 1'b0, "mem_timeout");
        check("mem_timeout_fault", int'(fault), 1);

        // Retire counter wraps modulo 8.
        do_reset();
        for (int k = 0; k < 9; k++) run(OP_STUR, 0, 0, 1'b0, "stur9");
        check("retired_wrap", int'(retired), 1);

        // Reset asserted mid-MEM drops the request at once.
        do_reset();
        run(OP_ADD, 0, 0, 1'b0, "pre");
        step(IREQ | IRW, 1'b1, 1'b0, OP_STUR, "abort_fetch");
        step(R2L, 1'b0, 1'b0, 11'd0, "abort_decode");
        step(R2L | ASRC | {12'b0, 4'b0010, 1'b0}, 1'b0, 1'b0, 11'd0, "abort_exec");
        imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_vec = DREQ | ASRC | MWR | {12'b0, 4'b0010, 1'b0};
        exp_ret = RW'(ret_m);
        tag = "abort_mem";
        @(negedge clk);
        #1;
        chk_en = 0;
        reset = 1'b1;
        ret_m = 0;
        #1;
        check("abort_dmem_req", int'(dmem_req), 0);
        check("abort_retired", int'(retired), 0);
        check("abort_imem_req", int'(imem_req), 0);
        @(posedge clk);
        #1;
        step('0, 1'b1, 1'b1, 11'd0, "abort_reset");
        reset = 1'b0;
        run(OP_ADD, 0, 0, 1'b0, "restart");
        check("restart_retired", int'(retired), 1);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
